// File: rtl/hyper_eot_router.sv
// hyper_eot_router
// Multi-channel read/write EOT classifier. Each channel keeps a small FIFO of
// direction tags (1 = read, 0 = write) that uDMA RX/TX events push. Each
// controller EOT pops one tag and turns it into a read-EOT or write-EOT pulse.
// Within a cycle the pop happens before the pushes. When the FIFO is empty, an
// EOT takes the first tag pushed in the same cycle. If nothing is pushed, it
// falls back to the last direction seen and pulses udf.
// All outputs are registered.

module hyper_eot_router #(
  parameter  int NB_CH = 2,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                sys_clk_i,
  input  logic                rstn_i,
  input  logic [NB_CH-1:0]    clr_i,
  input  logic [NB_CH-1:0]    rx_evt_i,
  input  logic [NB_CH-1:0]    tx_evt_i,
  input  logic [NB_CH-1:0]    eot_i,
  output logic [NB_CH-1:0]    evt_rx_o,
  output logic [NB_CH-1:0]    evt_tx_o,
  output logic [NB_CH-1:0]    evt_rd_eot_o,
  output logic [NB_CH-1:0]    evt_wr_eot_o,
  output logic [NB_CH-1:0]    ovf_o,
  output logic [NB_CH-1:0]    udf_o,
  output logic [NB_CH*CW-1:0] pending_o
);

  localparam int AW = $clog2(DEPTH);

  // Per-channel next-cycle event pulses, gathered here and registered below
  logic [NB_CH-1:0] w_rdEot;
  logic [NB_CH-1:0] w_wrEot;
  logic [NB_CH-1:0] w_ovf;
  logic [NB_CH-1:0] w_udf;

  for (genvar ch = 0; ch < NB_CH; ch++) begin : g_ch

    logic [DEPTH-1:0] r_fifo;
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    r_wrPtr;
    logic [CW-1:0]    r_count;
    logic             r_lastDir;

    logic             w_pop;
    logic             w_popTag;
    logic             w_underflow;
    logic             w_overflow;
    logic [1:0]       w_remN;
    logic             w_rem0;
    logic [1:0]       w_keepN;
    logic [CW-1:0]    w_cntAfterPop;
    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_nextCount;
    logic [AW-1:0]    w_nextRdPtr;
    logic [AW-1:0]    w_wrPtrPlus1;

    // Pop first, then fit the remaining pushes into the slots left after the pop
    always_comb begin
      w_pop         = eot_i[ch];
      w_popTag      = r_lastDir;
      w_underflow   = 1'b0;
      w_overflow    = 1'b0;
      w_cntAfterPop = r_count;
      w_nextRdPtr   = r_rdPtr;
      w_remN        = {1'b0, rx_evt_i[ch]} + {1'b0, tx_evt_i[ch]};
      w_rem0        = rx_evt_i[ch];
      w_keepN       = 2'd0;
      w_free        = '0;
      w_nextCount   = r_count;
      w_wrPtrPlus1  = r_wrPtr + AW'(1);

      if (w_pop) begin
        if (r_count != '0) begin
          w_popTag      = r_fifo[r_rdPtr];
          w_cntAfterPop = r_count - CW'(1);
          w_nextRdPtr   = r_rdPtr + AW'(1);
        end else if (rx_evt_i[ch] || tx_evt_i[ch]) begin
          // Empty FIFO: the EOT consumes the oldest same-cycle push (rx when both)
          w_popTag = rx_evt_i[ch];
          w_remN   = (rx_evt_i[ch] && tx_evt_i[ch]) ? 2'd1 : 2'd0;
          w_rem0   = 1'b0;
        end else begin
          w_underflow = 1'b1;
        end
      end

      w_free = CW'(DEPTH) - w_cntAfterPop;
      if (CW'(w_remN) > w_free) begin
        // At most one slot can be free here; the youngest push is the one dropped
        w_keepN    = w_free[1:0];
        w_overflow = 1'b1;
      end else begin
        w_keepN = w_remN;
      end

      w_nextCount = w_cntAfterPop + CW'(w_keepN);
    end

    // Tag storage, pointers, occupancy and last direction; a flush overrides everything
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_fifo    <= '0;
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
        r_count   <= '0;
        r_lastDir <= 1'b0;
      end else if (clr_i[ch]) begin
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
        r_count   <= '0;
        r_lastDir <= 1'b0;
      end else begin
        if (w_pop) begin
          r_lastDir <= w_popTag;
        end
        if (w_keepN != 2'd0) begin
          r_fifo[r_wrPtr] <= w_rem0;
        end
        if (w_keepN == 2'd2) begin
          r_fifo[w_wrPtrPlus1] <= 1'b0;
        end
        r_rdPtr <= w_nextRdPtr;
        r_wrPtr <= r_wrPtr + AW'(w_keepN);
        r_count <= w_nextCount;
      end
    end

    assign w_rdEot[ch] = !clr_i[ch] && w_pop && w_popTag;
    assign w_wrEot[ch] = !clr_i[ch] && w_pop && !w_popTag;
    assign w_ovf[ch]   = !clr_i[ch] && w_overflow;
    assign w_udf[ch]   = !clr_i[ch] && w_underflow;

    assign pending_o[ch*CW +: CW] = r_count;

  end

  // Register all event outputs so every pulse lands exactly one cycle after its cause
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      evt_rx_o     <= '0;
      evt_tx_o     <= '0;
      evt_rd_eot_o <= '0;
      evt_wr_eot_o <= '0;
      ovf_o        <= '0;
      udf_o        <= '0;
    end else begin
      evt_rx_o     <= rx_evt_i;
      evt_tx_o     <= tx_evt_i;
      evt_rd_eot_o <= w_rdEot;
      evt_wr_eot_o <= w_wrEot;
      ovf_o        <= w_ovf;
      udf_o        <= w_udf;
    end
  end

endmodule

// File: tb/tb_hyper_eot_router.sv
// tb_hyper_eot_router
// Scoreboard bench: the driver applies one cycle of inputs at each falling edge.
// A queue-based model of the tag FIFOs computes the expected registered
// outputs, which are pushed onto a queue. The monitor pops that queue after
// every rising edge and compares the popped values with the DUT outputs.

module tb_hyper_eot_router;

  localparam int NB_CH = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [NB_CH-1:0]    rx;
    logic [NB_CH-1:0]    tx;
    logic [NB_CH-1:0]    rd;
    logic [NB_CH-1:0]    wr;
    logic [NB_CH-1:0]    ovf;
    logic [NB_CH-1:0]    udf;
    logic [NB_CH*CW-1:0] pend;
  } exp_t;

  logic                sys_clk_i;
  logic                rstn_i;
  logic [NB_CH-1:0]    clr_i;
  logic [NB_CH-1:0]    rx_evt_i;
  logic [NB_CH-1:0]    tx_evt_i;
  logic [NB_CH-1:0]    eot_i;
  logic [NB_CH-1:0]    evt_rx_o;
  logic [NB_CH-1:0]    evt_tx_o;
  logic [NB_CH-1:0]    evt_rd_eot_o;
  logic [NB_CH-1:0]    evt_wr_eot_o;
  logic [NB_CH-1:0]    ovf_o;
  logic [NB_CH-1:0]    udf_o;
  logic [NB_CH*CW-1:0] pending_o;

  int   checkCount = 0;
  int   errorCount = 0;
  exp_t expQ[$];

  bit   tagQ[NB_CH][$];
  bit   lastDir[NB_CH];

  hyper_eot_router #(.NB_CH(NB_CH), .DEPTH(DEPTH)) dut (
    .sys_clk_i    (sys_clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (clr_i),
    .rx_evt_i     (rx_evt_i),
    .tx_evt_i     (tx_evt_i),
    .eot_i        (eot_i),
    .evt_rx_o     (evt_rx_o),
    .evt_tx_o     (evt_tx_o),
    .evt_rd_eot_o (evt_rd_eot_o),
    .evt_wr_eot_o (evt_wr_eot_o),
    .ovf_o        (ovf_o),
    .udf_o        (udf_o),
    .pending_o    (pending_o)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: FIFO of tags per channel, pop before push, drop beyond DEPTH
  function automatic exp_t modelStep(input logic [NB_CH-1:0] clr, input logic [NB_CH-1:0] rx,
                                     input logic [NB_CH-1:0] tx, input logic [NB_CH-1:0] eot);
    exp_t e;
    bit   pushes[$];
    bit   tag;
    e = '0;
    e.rx = rx;
    e.tx = tx;
    for (int ch = 0; ch < NB_CH; ch++) begin
      if (clr[ch]) begin
        tagQ[ch].delete();
        lastDir[ch] = 1'b0;
      end else begin
        pushes.delete();
        if (rx[ch]) pushes.push_back(1'b1);
        if (tx[ch]) pushes.push_back(1'b0);
        if (eot[ch]) begin
          if (tagQ[ch].size() > 0) begin
            tag = tagQ[ch].pop_front();
          end else if (pushes.size() > 0) begin
            tag = pushes.pop_front();
          end else begin
            tag = lastDir[ch];
            e.udf[ch] = 1'b1;
          end
          lastDir[ch] = tag;
          if (tag) e.rd[ch] = 1'b1;
          else     e.wr[ch] = 1'b1;
        end
        foreach (pushes[i]) begin
          if (tagQ[ch].size() < DEPTH) tagQ[ch].push_back(pushes[i]);
          else                         e.ovf[ch] = 1'b1;
        end
      end
      e.pend[ch*CW +: CW] = CW'(tagQ[ch].size());
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [NB_CH-1:0] clr, input logic [NB_CH-1:0] rx,
                               input logic [NB_CH-1:0] tx, input logic [NB_CH-1:0] eot);
    @(negedge sys_clk_i);
    clr_i    = clr;
    rx_evt_i = rx;
    tx_evt_i = tx;
    eot_i    = eot;
    expQ.push_back(modelStep(clr, rx, tx, eot));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_evt_rx"}, 32'(evt_rx_o), 32'd0);
    checkOutput({tag, "_evt_tx"}, 32'(evt_tx_o), 32'd0);
    checkOutput({tag, "_rd_eot"}, 32'(evt_rd_eot_o), 32'd0);
    checkOutput({tag, "_wr_eot"}, 32'(evt_wr_eot_o), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(ovf_o), 32'd0);
    checkOutput({tag, "_udf"}, 32'(udf_o), 32'd0);
    checkOutput({tag, "_pending"}, 32'(pending_o), 32'd0);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the oldest expectation
  always @(posedge sys_clk_i) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("evt_rx", 32'(evt_rx_o), 32'(e.rx));
      checkOutput("evt_tx", 32'(evt_tx_o), 32'(e.tx));
      checkOutput("rd_eot", 32'(evt_rd_eot_o), 32'(e.rd));
      checkOutput("wr_eot", 32'(evt_wr_eot_o), 32'(e.wr));
      checkOutput("ovf", 32'(ovf_o), 32'(e.ovf));
      checkOutput("udf", 32'(udf_o), 32'(e.udf));
      checkOutput("pending", 32'(pending_o), 32'(e.pend));
      checkOutput("rd_wr_exclusive", 32'(evt_rd_eot_o & evt_wr_eot_o), 32'd0);
    end
  end

  initial begin
    int pushPct;
    int eotPct;
    logic [NB_CH-1:0] rx, tx, eot, clr;

    rstn_i   = 1'b0;
    clr_i    = '0;
    rx_evt_i = '0;
    tx_evt_i = '0;
    eot_i    = '0;
    for (int ch = 0; ch < NB_CH; ch++) begin
      tagQ[ch].delete();
      lastDir[ch] = 1'b0;
    end
    repeat (3) @(posedge sys_clk_i);
    #1;
    checkAllZero("reset");
    @(negedge sys_clk_i);
    rstn_i = 1'b1;

    $display("[TB] T1 single read on ch0");
    applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
    idle(2);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01);
    idle(1);

    $display("[TB] T2 tx,rx,tx then three EOTs on ch0");
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00);
    applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b01, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01);
    idle(1);

    $display("[TB] T3 overflow after DEPTH reads on ch0");
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(2'b00, 2'b01, 2'b00, 2'b00);
    applyStimulus(2'b00, 2'b01, 2'b01, 2'b01);
    applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);

    $display("[TB] T4 underflow on ch1 falls back to last read direction");
    applyStimulus(2'b00, 2'b10, 2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b10);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b10);
    idle(1);

    $display("[TB] T5 empty ch0 with rx+tx+eot in one cycle");
    applyStimulus(2'b00, 2'b01, 2'b01, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01);
    idle(1);

    $display("[TB] T6 flush ch0 alongside EOT, ch1 keeps running");
    applyStimulus(2'b00, 2'b11, 2'b00, 2'b00);
    applyStimulus(2'b00, 2'b01, 2'b10, 2'b00);
    applyStimulus(2'b01, 2'b01, 2'b01, 2'b11);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b11);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b01);
    idle(1);

    $display("[TB] random traffic");
    for (int seg = 0; seg < 12; seg++) begin
      pushPct = $urandom_range(10, 70);
      eotPct  = $urandom_range(10, 70);
      for (int i = 0; i < 120; i++) begin
        for (int ch = 0; ch < NB_CH; ch++) begin
          rx[ch]  = ($urandom_range(0, 99) < pushPct);
          tx[ch]  = ($urandom_range(0, 99) < pushPct);
          eot[ch] = ($urandom_range(0, 99) < eotPct);
          clr[ch] = ($urandom_range(0, 99) < 2);
        end
        applyStimulus(clr, rx, tx, eot);
      end
    end

    $display("[TB] asynchronous reset with tags queued");
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b11, 2'b10, 2'b00);
    idle(1);
    @(negedge sys_clk_i);
    rstn_i = 1'b0;
    #1;
    checkAllZero("async_reset");
    for (int ch = 0; ch < NB_CH; ch++) begin
      tagQ[ch].delete();
      lastDir[ch] = 1'b0;
    end
    @(negedge sys_clk_i);
    rstn_i = 1'b1;
    idle(2);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b11);
    applyStimulus(2'b00, 2'b10, 2'b01, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b00, 2'b11);
    idle(2);

    repeat (3) @(posedge sys_clk_i);
    #2;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
